// File: rtl/prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_queue_pkg;

    // Native instruction/address width that the entry layout is built for.
    localparam int PACK_XLEN = 32;

    // First fetch address after reset.
    localparam logic [PACK_XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    // One decoded-ready entry: the fetch address and the word returned for it.
    typedef struct packed {
        logic [PACK_XLEN-1:0] programCounter;
        logic [PACK_XLEN-1:0] instruction;
    } entry_t;

    // Force an address onto a word boundary.
    function automatic logic [PACK_XLEN-1:0] alignWord(input logic [PACK_XLEN-1:0] address);
        return address & ~(PACK_XLEN'(3));
    endfunction

endpackage

// File: rtl/prefetch_queue_sync_fifo.sv
// Small synchronous FIFO with a flush input. Head data reads as zero when
// empty so downstream registered outputs have a defined reset/flush value.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     pushValid,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     popValid,
    output logic [WIDTH-1:0]         popData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    writePtr;
    logic [AW-1:0]    readPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPush  = pushValid && !full;
    assign doPop   = popValid && !empty;
    assign popData = empty ? '0 : storage[readPtr];

    // Pointer and occupancy bookkeeping; clear drops all entries at once.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            writePtr <= '0;
            readPtr  <= '0;
            count    <= '0;
        end else begin
            if (doPush) writePtr <= writePtr + 1'b1;
            if (doPop)  readPtr  <= readPtr + 1'b1;
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    // Entry storage write port.
    always_ff @(posedge clock) begin
        if (doPush && !reset && !clear) begin
            storage[writePtr] <= pushData;
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, keeps their
// addresses as tags, pairs in-order responses with tags into a decode queue,
// and on a redirect flushes and discards responses still in flight.
//
// Handshakes: a transfer happens on a channel exactly in the cycle where its
// valid and ready are both high (requestValid/requestReady,
// outValid/outReady); valid never depends on ready. Responses have no ready:
// every responseValid cycle delivers one word.
module prefetch_queue #(
    parameter int               DEPTH        = 4,
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = prefetch_queue_pkg::RESET_VECTOR
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirectValid,
    input  logic [XLEN-1:0]  redirectAddress,
    output logic             requestValid,
    output logic [XLEN-1:0]  requestAddress,
    input  logic             requestReady,
    input  logic             responseValid,
    input  logic [XLEN-1:0]  responseData,
    output logic             outValid,
    output logic [XLEN-1:0]  outInstruction,
    output logic [XLEN-1:0]  outProgramCounter,
    input  logic             outReady
);

    import prefetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetchPc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discardCount;
    logic [CW-1:0]   nextOutstanding;
    logic [CW-1:0]   queueCount;
    logic [CW-1:0]   tagCount;
    logic            queueEmpty;
    logic            tagEmpty;
    logic [XLEN-1:0] tagHead;
    logic [CW:0]     creditsUsed;
    logic            accept;
    logic            responseTaken;
    logic            responseDropped;
    logic            responseKept;
    logic            popHead;
    entry_t          pushEntry;
    entry_t          headEntry;

    // Queued entries plus in-flight fetches (including ones to be discarded)
    // never exceed DEPTH, which is what makes queue overflow impossible.
    assign creditsUsed    = {1'b0, queueCount} + {1'b0, outstanding};
    assign requestValid   = !reset && !redirectValid && (creditsUsed < CREDIT_LIMIT)
                            && (tagCount != CW'(DEPTH));
    assign requestAddress = fetchPc;
    assign accept         = requestValid && requestReady;

    // A response with nothing outstanding is stray and ignored entirely.
    assign responseTaken   = responseValid && (outstanding != '0);
    assign responseDropped = responseTaken && (discardCount != '0);
    assign responseKept    = responseTaken && (discardCount == '0) && !redirectValid && !tagEmpty;

    // Redirect wins over a pop in the same cycle; the head is flushed anyway.
    assign popHead = outValid && outReady && !redirectValid;

    assign nextOutstanding = outstanding + CW'(accept) - CW'(responseTaken);

    assign pushEntry.programCounter = tagHead;
    assign pushEntry.instruction    = responseData;

    assign outValid          = !queueEmpty;
    assign outInstruction    = headEntry.instruction;
    assign outProgramCounter = headEntry.programCounter;

    // Fetch PC, in-flight count and pending-discard count.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetchPc      <= RESET_VECTOR;
            outstanding  <= '0;
            discardCount <= '0;
        end else if (redirectValid) begin
            fetchPc      <= alignWord(redirectAddress);
            outstanding  <= nextOutstanding;
            discardCount <= nextOutstanding;
        end else begin
            if (accept) fetchPc <= fetchPc + XLEN'(4);
            outstanding <= nextOutstanding;
            if (responseDropped) discardCount <= discardCount - CW'(1);
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) tagFifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirectValid),
        .pushValid (accept),
        .pushData  (fetchPc),
        .popValid  (responseKept),
        .popData   (tagHead),
        .count     (tagCount),
        .empty     (tagEmpty)
    );

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) entryQueue (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirectValid),
        .pushValid (responseKept),
        .pushData  (pushEntry),
        .popValid  (popHead),
        .popData   (headEntry),
        .count     (queueCount),
        .empty     (queueEmpty)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios plus a randomized run, checked
// against a memory model and an ordered stream of expected fetch addresses.
module tb_prefetch_queue;

    localparam int              XLEN     = 32;
    localparam int              DEPTH    = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    logic            clock = 1'b0;
    logic            reset;
    logic            redirectValid;
    logic [XLEN-1:0] redirectAddress;
    logic            requestValid;
    logic [XLEN-1:0] requestAddress;
    logic            requestReady;
    logic            responseValid;
    logic [XLEN-1:0] responseData;
    logic            outValid;
    logic [XLEN-1:0] outInstruction;
    logic [XLEN-1:0] outProgramCounter;
    logic            outReady;

    prefetch_queue #(
        .DEPTH        (DEPTH),
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_PC)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .redirectValid     (redirectValid),
        .redirectAddress   (redirectAddress),
        .requestValid      (requestValid),
        .requestAddress    (requestAddress),
        .requestReady      (requestReady),
        .responseValid     (responseValid),
        .responseData      (responseData),
        .outValid          (outValid),
        .outInstruction    (outInstruction),
        .outProgramCounter (outProgramCounter),
        .outReady          (outReady)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int checkCount = 0;
    int errorCount = 0;
    int cyc = 0;
    int acceptCount = 0;

    logic [XLEN-1:0] exp_q[$];      // fetch addresses decode must see, in order
    logic [XLEN-1:0] memAddr[$];    // memory: accepted requests awaiting response
    int              memDue[$];
    logic [XLEN-1:0] expFetchPc;

    logic            sampledOutValid;
    logic [XLEN-1:0] sampledOutPc;
    logic            sampledReqValid;
    logic [XLEN-1:0] sampledReqAddr;

    function automatic logic [XLEN-1:0] memWord(input logic [XLEN-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One clock cycle: drive inputs, sample combinational view, update model.
    task automatic stepCycle(input logic rr, input logic orr, input logic redir,
                             input logic [XLEN-1:0] raddr, input int latency);
        logic [XLEN-1:0] pc;
        requestReady    = rr;
        outReady        = orr;
        redirectValid   = redir;
        redirectAddress = raddr;
        if (memAddr.size() > 0 && memDue[0] <= cyc) begin
            responseValid = 1'b1;
            responseData  = memWord(memAddr[0]);
        end else begin
            responseValid = 1'b0;
            responseData  = $urandom;
        end
        #2;
        sampledOutValid = outValid;
        sampledOutPc    = outProgramCounter;
        sampledReqValid = requestValid;
        sampledReqAddr  = requestAddress;
        if (redir) checkValue("noRequestDuringRedirect", 32'(requestValid), 32'd0);
        if (requestValid && requestReady) begin
            checkValue("requestAddress", requestAddress, expFetchPc);
            memAddr.push_back(requestAddress);
            memDue.push_back(cyc + latency);
            exp_q.push_back(requestAddress);
            expFetchPc = expFetchPc + 32'd4;
            acceptCount++;
        end
        if (outValid && outReady && !redir) begin
            if (exp_q.size() == 0) begin
                checkValue("outWithNothingPending", 32'(outValid), 32'd0);
            end else begin
                pc = exp_q.pop_front();
                checkValue("outProgramCounter", outProgramCounter, pc);
                checkValue("outInstruction", outInstruction, memWord(pc));
            end
        end
        if (responseValid) begin
            void'(memAddr.pop_front());
            void'(memDue.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            expFetchPc = raddr & ~32'd3;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Reset for one edge (memory model resets too), then release.
    task automatic doReset();
        reset           = 1'b1;
        redirectValid   = 1'b0;
        redirectAddress = '0;
        requestReady    = 1'b0;
        responseValid   = 1'b0;
        responseData    = '0;
        outReady        = 1'b0;
        memAddr.delete();
        memDue.delete();
        exp_q.delete();
        expFetchPc = RESET_PC;
        @(posedge clock);
        #1;
        checkValue("rstOutValid", 32'(outValid), 32'd0);
        checkValue("rstOutPc", outProgramCounter, 32'd0);
        checkValue("rstOutInstr", outInstruction, 32'd0);
        checkValue("rstRequestValid", 32'(requestValid), 32'd0);
        checkValue("rstDiscard", 32'(dut.discardCount), 32'd0);
        reset = 1'b0;
        #1;
        checkValue("firstRequestValid", 32'(requestValid), 32'd1);
        checkValue("firstRequestAddr", requestAddress, RESET_PC);
        cyc = 0;
    endtask

    initial begin
        int startAccept;
        int expDiscard;
        logic [XLEN-1:0] firstPc;
        bit found;
        logic rr, orr, redir;

        doReset();

        // Streaming with latency 1: one instruction per cycle from cycle 2.
        for (int k = 0; k < 10; k++) begin
            stepCycle(1'b1, 1'b1, 1'b0, '0, 1);
            if (k >= 2) begin
                checkValue("streamValid", 32'(sampledOutValid), 32'd1);
                checkValue("streamPc", sampledOutPc, 32'(4 * (k - 2)));
            end
        end

        // Decode stalled: exactly DEPTH requests, then one refill per pop.
        doReset();
        startAccept = acceptCount;
        repeat (10) stepCycle(1'b1, 1'b0, 1'b0, '0, 1);
        checkValue("fillCount", 32'(acceptCount - startAccept), 32'(DEPTH));
        checkValue("fullRequestValid", 32'(sampledReqValid), 32'd0);
        checkValue("fullOutValid", 32'(sampledOutValid), 32'd1);
        checkValue("fullHeadPc", sampledOutPc, 32'h0);
        for (int p = 0; p < 2; p++) begin
            startAccept = acceptCount;
            stepCycle(1'b1, 1'b1, 1'b0, '0, 1);
            repeat (4) stepCycle(1'b1, 1'b0, 1'b0, '0, 1);
            checkValue("refillPerPop", 32'(acceptCount - startAccept), 32'd1);
        end

        // Latency 3, redirect with two outstanding: both dropped.
        doReset();
        stepCycle(1'b1, 1'b1, 1'b0, '0, 3);
        stepCycle(1'b1, 1'b1, 1'b0, '0, 3);
        stepCycle(1'b0, 1'b1, 1'b1, 32'h100, 3);
        checkValue("discardAfterRedirect", 32'(dut.discardCount), 32'd2);
        firstPc = '1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            stepCycle(1'b1, 1'b1, 1'b0, '0, 3);
            if (sampledOutValid) begin
                found = 1'b1;
                firstPc = sampledOutPc;
            end
        end
        checkValue("firstPcAfterRedirect", firstPc, 32'h100);

        // Unaligned redirect target.
        doReset();
        repeat (3) stepCycle(1'b1, 1'b1, 1'b0, '0, 1);
        stepCycle(1'b1, 1'b1, 1'b1, 32'h203, 1);
        stepCycle(1'b1, 1'b1, 1'b0, '0, 1);
        checkValue("alignedReqValid", 32'(sampledReqValid), 32'd1);
        checkValue("alignedReqAddr", sampledReqAddr, 32'h200);

        // Redirect coinciding with a pop and a response.
        doReset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (i > 2 && outValid && memAddr.size() > 0 && memDue[0] <= cyc) found = 1'b1;
            else stepCycle(1'b1, 1'b1, 1'b0, '0, 3);
        end
        checkValue("redirectWindowFound", 32'(found), 32'd1);
        expDiscard = memAddr.size() - ((memAddr.size() > 0 && memDue[0] <= cyc) ? 1 : 0);
        stepCycle(1'b1, 1'b1, 1'b1, 32'h400, 3);
        checkValue("flushEmpty", 32'(outValid), 32'd0);
        checkValue("discardOutstandingMinus1", 32'(dut.discardCount), 32'(expDiscard));
        repeat (10) stepCycle(1'b1, 1'b1, 1'b0, '0, 3);

        // Reset in the middle of a stream with fetches in flight.
        repeat (3) stepCycle(1'b1, 1'b1, 1'b0, '0, 3);
        doReset();
        repeat (8) stepCycle(1'b1, 1'b1, 1'b0, '0, 2);

        // Randomized traffic with occasional redirects.
        doReset();
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 400; i++) begin
                rr    = ($urandom_range(99) < 70);
                orr   = ($urandom_range(99) < (40 + 25 * seg));
                redir = ($urandom_range(99) < 4);
                stepCycle(rr, orr, redir, $urandom, $urandom_range(4, 1));
            end
        end

        // Drain: stop fetching and let everything reach decode.
        for (int i = 0; i < 100 && (memAddr.size() > 0 || exp_q.size() > 0); i++) begin
            stepCycle(1'b0, 1'b1, 1'b0, '0, 1);
        end
        checkValue("drainedPending", 32'(exp_q.size()), 32'd0);
        checkValue("drainOutValid", 32'(outValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the queue entries and the maximum of queued plus outstanding fetches; power of two, >= 2.
REQ-002 Parameter XLEN, default 32, SHALL be the instruction and address width.
REQ-003 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 redirectValid  input  1  flush the queue and restart fetch at redirectAddress (branch, trap or mret).
REQ-007 redirectAddress  input  XLEN  new fetch address; bits [1:0] ignored and treated as 0.
REQ-008 requestValid  output  1  fetch request to instruction memory.
REQ-009 requestAddress  output  XLEN  word-aligned fetch address.
REQ-010 requestReady  input  1  memory accepts the request this cycle.
REQ-011 responseValid  input  1  in-order instruction return.
REQ-012 responseData  input  XLEN  returned instruction word.
REQ-013 outValid  output  1  head entry is available to decode.
REQ-014 outInstruction  output  XLEN  head instruction.
REQ-015 outProgramCounter  output  XLEN  address of the head instruction.
REQ-016 outReady  input  1  decode consumes the head this cycle.

Function
REQ-017 A request SHALL issue only when (occupancy + outstanding) < DEPTH and redirectValid is 0; it is accepted when requestValid && requestReady.
REQ-018 On acceptance the fetch PC SHALL advance by 4 (mod 2^XLEN wrap), outstanding SHALL increment, and the request address SHALL be pushed to a tag FIFO.
REQ-019 Responses SHALL arrive in order with latency >= 1 cycle; each non-discarded response pops the tag FIFO and pushes {tag, responseData} into the queue.
REQ-020 A response pushed in cycle N SHALL be visible on outValid in cycle N+1; there is no bypass.
REQ-021 Pop SHALL occur on outValid && outReady; a simultaneous push and pop SHALL both take effect.
REQ-022 outValid, outInstruction and outProgramCounter SHALL be driven from registered queue state.
REQ-023 On redirectValid: the queue and the tag FIFO SHALL be cleared, the fetch PC SHALL be loaded with {redirectAddress[XLEN-1:2],2'b00}, and discardCount SHALL be set to outstanding, plus 1 if a request is accepted that cycle, minus 1 if a response arrives that cycle; outstanding SHALL track the same value.
REQ-024 While discardCount > 0, each responseValid SHALL be dropped and SHALL decrement discardCount and outstanding.
REQ-025 Requests to the new address MAY issue while discards are pending, subject to REQ-017 credits.
REQ-026 Redirect SHALL take priority over a simultaneous pop, push or request in the same cycle.
REQ-027 Overflow SHALL be impossible by construction; a response arriving while outstanding == 0 SHALL be ignored.
REQ-028 When full with an outstanding count of 0, requestValid SHALL stay 0 until a pop occurs.

Reset
REQ-029 On reset: fetch PC = RESET_VECTOR, queue empty, tag FIFO empty, outstanding = 0, discardCount = 0, outValid = 0, requestValid = 0, outInstruction = 0, outProgramCounter = 0.
REQ-030 Reset SHALL override redirect, and responses in flight at reset SHALL NOT be discarded; the memory is reset in the same cycle.
REQ-031 The first request SHALL issue in the cycle after reset deasserts.

Structure
REQ-032 The entry struct {programCounter, instruction} and the RESET_VECTOR constant SHALL reside in pack.
REQ-033 Counter widths SHALL be $clog2(DEPTH)+1.
REQ-034 One sub-module, sync_fifo (parametrised width and depth, with clear), SHALL be instantiated for both the tag FIFO and the entry queue.

Verification
REQ-035 Reset, then requestReady=1 with fixed latency 1 and outReady=1 -> outProgramCounter shows 0x0, 0x4, 0x8, ... with one instruction per cycle from cycle 3 onward.
REQ-036 outReady=0, DEPTH=4 -> exactly 4 requests issue, then requestValid=0 and outValid=1 with PC 0x0 held; raising outReady issues one new request per pop.
REQ-037 Latency 3, redirect to 0x100 with 2 outstanding -> the next 2 responses are dropped and the first outProgramCounter after the redirect is 0x100.
REQ-038 redirectAddress=0x203 -> requestAddress=0x200.
REQ-039 Redirect in the same cycle as a pop and a response -> the queue is empty next cycle and discardCount equals outstanding minus 1.
REQ-040 Assert reset during an active stream with 3 in flight -> all outputs match REQ-029 next cycle and fetch restarts at RESET_VECTOR.
